traffic_ctrl: RTL and testbench
===============================

# traffic_ctrl

Traffic-light phase controller that sits in front of the 6-bit duration register file and drives the lamps. It forwards configuration writes from the user side into the register file and keeps a shadow copy of the red, green and yellow durations. It sequences RED → GREEN → YELLOW → RED, counting each phase down in seconds, and shows a blinking yellow while idle.

## Interface
- DW, 6, duration / countdown width in seconds
- AW, 2, register-file address width
- clk  in  1  system clock; all state changes on posedge
- rst_n  in  1  asynchronous, active-low reset
- run  in  1  level; 1 = cycle phases, 0 = idle blink
- tick  in  1  one-cycle pulse, 1 s time base; never asserted on consecutive cycles
- cfg_we  in  1  one-cycle write request from configuration side
- cfg_addr  in  AW  0 = red, 1 = green, 2 = yellow; 3 is forwarded to the register file but never read back
- cfg_data  in  DW  duration to write
- rf_cs  out  1  register-file chip select, tied 0 (always selected, active-low)
- rf_w_r  out  1  register-file write strobe = cfg_we (combinational)
- rf_addr  out  AW  = cfg_addr (combinational)
- rf_w_data  out  DW  = cfg_data (combinational)
- rf_r, rf_g, rf_y  in  DW each  register-file read ports; valid only in cycles where rf_w_r = 0, otherwise high-Z
- lamp_r, lamp_g, lamp_y  out  1 each  registered lamp drives
- remain  out  DW  registered seconds left in the current phase
- phase_done  out  1  registered one-cycle pulse on every phase transition RED→GREEN, GREEN→YELLOW, YELLOW→RED

## Operation
- **Reset values:** state IDLE, lamps 0, remain 0, phase_done 0, shadow_r/g/y 0, blink 0.
- **Shadow registers:**
  - On each posedge with cfg_we = 0: shadow_r/g/y ← rf_r/g/y.
  - With cfg_we = 1 the shadows hold, because the read ports are Z that cycle.
- **Phase load:** remain ← max(shadow_x, 1). A stored duration of 0 runs as 1 s. Countdown never underflows.
- **IDLE:**
  - lamp_r = lamp_g = 0, lamp_y = blink, remain = 0.
  - blink toggles on each tick.
  - run = 1 → RED at the next edge, loading shadow_r. blink is cleared. phase_done does not pulse on entry.
- **RED / GREEN / YELLOW:**
  - The lamp matching the state is 1; the other two are 0.
  - On tick with remain > 1: remain decrements.
  - On tick with remain = 1: advance to the next phase, load its shadow duration, and pulse phase_done for one cycle.
  - With no tick, remain holds.
- **run = 0 in any phase:** go to IDLE at the next edge. This takes priority over a simultaneous tick. Lamps are all 0 and blink restarts at 0.
- **Phase-entry timing:** the value loaded is the shadow contents before that edge.

## Timing
- **Register-file write path:** cfg_* → rf_* has zero latency. The register file commits at the same posedge.
- **Write-to-phase-load latency:** a value written at edge k reaches the shadow at edge k+1 at the earliest (needs cfg_we = 0 in that cycle). Phases entered at or before edge k+1 use the old value.
- **Running phase isolation:** writes never alter remain of the phase already running.
- **Tick response:** tick sampled at edge k updates remain, lamps and phase_done visible after edge k. Phase length = N ticks exactly.
- **cfg_we and tick in the same cycle:** both take effect independently.
- **Reset mid-operation:** asserting rst_n low forces all registered outputs to reset values immediately, not waiting for clk. Release is synchronous to the next posedge.

## Structure
- **Package traffic_pkg:**
  - state enum IDLE, RED, GREEN, YELLOW
  - address constants ADDR_RED = 0, ADDR_GREEN = 1, ADDR_YELLOW = 2
  - DW / AW defaults
- **Sub-module phase_timer:**
  - Loadable DW-bit down-counter: load, load_val, tick → remain, expire (remain = 1 & tick).
  - Clamping to 1 is done inside phase_timer.
- **Top level:** holds FSM, shadow registers, blink flop and rf_* pass-through.

## Test plan
- **Reset:** assert rst_n = 0 mid-cycle → lamps 000, remain 0, phase_done 0 immediately, before any clk edge. Release and run = 0 → lamp_y toggles 0→1→0 on successive ticks.
- **Basic cycle:**
  - Stimulus: write red = 3, green = 2, yellow = 1; run = 1; tick every 4 cycles.
  - Required: RED with remain 3, 2, 1; GREEN 2, 1; YELLOW 1; back to RED 3.
  - phase_done pulses exactly 3 times per full cycle.
- **Zero duration:** write green = 0 → GREEN lasts exactly 1 tick with remain = 1.
- **Drop run mid-GREEN:** run = 0 with remain = 2, asserted together with a tick → IDLE next edge, remain 0, lamps off, no phase_done. Reassert run → RED reloaded with full red duration.
- **Write during RED:**
  - Stimulus: write green = 5 during RED, in the same cycle as a tick.
  - Required: red countdown unaffected; the following GREEN starts at 5.
  - Corner: a write issued in the cycle before a GREEN entry leaves that GREEN on the old value.
- **Stress:** back-to-back cfg_we for 4 cycles while run = 1 → shadows frozen, then update to the last written values. No X or Z ever propagates into remain.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic-light phase controller.
//   - state_e : controller states (idle blink plus the three lamp phases)
//   - ADDR_*  : register-file addresses of the three phase durations
//   - DW_DEF / AW_DEF : default duration and address widths
package traffic_pkg;

  localparam int DW_DEF = 6;
  localparam int AW_DEF = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RED    = 2'd1,
    GREEN  = 2'd2,
    YELLOW = 2'd3
  } state_e;

  localparam logic [AW_DEF-1:0] ADDR_RED    = 2'd0;
  localparam logic [AW_DEF-1:0] ADDR_GREEN  = 2'd1;
  localparam logic [AW_DEF-1:0] ADDR_YELLOW = 2'd2;

  // Phase that follows the given running phase (RED -> GREEN -> YELLOW -> RED).
  function automatic state_e next_phase(input state_e s);
    case (s)
      RED:     return GREEN;
      GREEN:   return YELLOW;
      default: return RED;
    endcase
  endfunction

endpackage

// File: rtl/traffic_ctrl_phase_timer.sv
// Loadable down-counter holding the seconds left in the current phase.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : force remain to 0 (idle)
//   load       : load load_val (a value of 0 is run as 1 s)
//   load_val   : duration to load
//   tick       : 1 s time-base pulse
//   remain     : registered seconds left
//   expire     : combinational, high on the tick that ends the phase
module phase_timer
  import traffic_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          load,
  input  logic [DW-1:0] load_val,
  input  logic          tick,
  output logic [DW-1:0] remain,
  output logic          expire
);

  localparam logic [DW-1:0] ONE = DW'(1);

  logic [DW-1:0] remain_q, remain_d;

  always_comb begin
    remain_d = remain_q;
    if (clr) begin
      remain_d = '0;
    end else if (load) begin
      // A stored duration of 0 still occupies one full tick.
      remain_d = (load_val == '0) ? ONE : load_val;
    end else if (tick && remain_q > ONE) begin
      remain_d = remain_q - ONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // the pre-edge value of every other flop, independent of process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) remain_q <= '0;
    else        remain_q <= remain_d;
  end

  assign remain = remain_q;
  assign expire = tick && (remain_q == ONE);

endmodule

// File: rtl/traffic_ctrl.sv
// Traffic-light phase controller.
// Forwards configuration writes to the external duration register file,
// keeps shadow copies of the red/green/yellow durations, and sequences
// RED -> GREEN -> YELLOW -> RED counting each phase down in seconds.
// While run = 0 the yellow lamp blinks on each tick.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   run                 : 1 = cycle phases, 0 = idle blink
//   tick                : 1 s time-base pulse
//   cfg_we/addr/data    : configuration write request
//   rf_cs/w_r/addr/w_data : register-file control (combinational pass-through)
//   rf_r/g/y            : register-file read ports (valid when rf_w_r = 0)
//   lamp_r/g/y          : registered lamp drives
//   remain              : registered seconds left in the current phase
//   phase_done          : registered pulse on each phase-to-phase transition
module traffic_ctrl
  import traffic_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  input  logic          tick,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [DW-1:0] cfg_data,
  output logic          rf_cs,
  output logic          rf_w_r,
  output logic [AW-1:0] rf_addr,
  output logic [DW-1:0] rf_w_data,
  input  logic [DW-1:0] rf_r,
  input  logic [DW-1:0] rf_g,
  input  logic [DW-1:0] rf_y,
  output logic          lamp_r,
  output logic          lamp_g,
  output logic          lamp_y,
  output logic [DW-1:0] remain,
  output logic          phase_done
);

  // Register-file pass-through: the file commits on the same edge.
  assign rf_cs     = 1'b0;
  assign rf_w_r    = cfg_we;
  assign rf_addr   = cfg_addr;
  assign rf_w_data = cfg_data;

  state_e        state_q, state_d;
  logic [DW-1:0] shadow_r_q, shadow_r_d;
  logic [DW-1:0] shadow_g_q, shadow_g_d;
  logic [DW-1:0] shadow_y_q, shadow_y_d;
  logic          blink_q, blink_d;
  logic          lamp_r_q, lamp_r_d;
  logic          lamp_g_q, lamp_g_d;
  logic          lamp_y_q, lamp_y_d;
  logic          phase_done_q, phase_done_d;

  logic          tmr_clr, tmr_load, tmr_expire;
  logic [DW-1:0] tmr_val;

  // Read ports float while a write is in flight, so the shadows hold then.
  assign shadow_r_d = cfg_we ? shadow_r_q : rf_r;
  assign shadow_g_d = cfg_we ? shadow_g_q : rf_g;
  assign shadow_y_d = cfg_we ? shadow_y_q : rf_y;

  // Selects the pre-edge shadow duration that belongs to a given phase.
  function automatic logic [DW-1:0] shadow_for(input state_e s,
                                                input logic [DW-1:0] r,
                                                input logic [DW-1:0] g,
                                                input logic [DW-1:0] y);
    case (s)
      GREEN:   return g;
      YELLOW:  return y;
      default: return r;
    endcase
  endfunction

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned -- that is what keeps this block free of inferred latches.
  always_comb begin
    state_d      = state_q;
    blink_d      = blink_q;
    tmr_clr      = 1'b0;
    tmr_load     = 1'b0;
    tmr_val      = shadow_r_q;
    phase_done_d = 1'b0;

    if (state_q == IDLE) begin
      if (run) begin
        state_d  = RED;
        tmr_load = 1'b1;
        tmr_val  = shadow_r_q;
        blink_d  = 1'b0;
      end else begin
        tmr_clr = 1'b1;
        if (tick) blink_d = ~blink_q;
      end
    end else if (!run) begin
      // Dropping run wins over a coincident tick.
      state_d = IDLE;
      tmr_clr = 1'b1;
      blink_d = 1'b0;
    end else if (tmr_expire) begin
      state_d      = next_phase(state_q);
      tmr_load     = 1'b1;
      tmr_val      = shadow_for(state_d, shadow_r_q, shadow_g_q, shadow_y_q);
      phase_done_d = 1'b1;
    end

    lamp_r_d = (state_d == RED);
    lamp_g_d = (state_d == GREEN);
    lamp_y_d = (state_d == YELLOW) || ((state_d == IDLE) && blink_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shadow_r_q   <= '0;
      shadow_g_q   <= '0;
      shadow_y_q   <= '0;
      blink_q      <= 1'b0;
      lamp_r_q     <= 1'b0;
      lamp_g_q     <= 1'b0;
      lamp_y_q     <= 1'b0;
      phase_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_r_q   <= shadow_r_d;
      shadow_g_q   <= shadow_g_d;
      shadow_y_q   <= shadow_y_d;
      blink_q      <= blink_d;
      lamp_r_q     <= lamp_r_d;
      lamp_g_q     <= lamp_g_d;
      lamp_y_q     <= lamp_y_d;
      phase_done_q <= phase_done_d;
    end
  end

  phase_timer #(.DW(DW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (tmr_clr),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tick     (tick),
    .remain   (remain),
    .expire   (tmr_expire)
  );

  assign lamp_r     = lamp_r_q;
  assign lamp_g     = lamp_g_q;
  assign lamp_y     = lamp_y_q;
  assign phase_done = phase_done_q;

endmodule

// File: tb/tb_traffic_ctrl.sv
// Self-checking bench for traffic_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_traffic_ctrl;
  import traffic_pkg::*;

  localparam int DW = 6;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0;
  logic          tick = 1'b0;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [DW-1:0] cfg_data = '0;
  logic          rf_cs, rf_w_r;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_w_data, rf_r, rf_g, rf_y;
  logic          lamp_r, lamp_g, lamp_y, phase_done;
  logic [DW-1:0] remain;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  traffic_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .tick       (tick),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .rf_cs      (rf_cs),
    .rf_w_r     (rf_w_r),
    .rf_addr    (rf_addr),
    .rf_w_data  (rf_w_data),
    .rf_r       (rf_r),
    .rf_g       (rf_g),
    .rf_y       (rf_y),
    .lamp_r     (lamp_r),
    .lamp_g     (lamp_g),
    .lamp_y     (lamp_y),
    .remain     (remain),
    .phase_done (phase_done)
  );

  // External register file: commits on the edge, read ports carry junk
  // while a write is in flight.
  logic [DW-1:0] rf_mem [4] = '{default: '0};
  logic [DW-1:0] garbage = '0;
  always @(posedge clk) if (rf_w_r) rf_mem[rf_addr] <= rf_w_data;
  always @(negedge clk) garbage <= DW'($urandom);
  assign rf_r = rf_w_r ? garbage : rf_mem[0];
  assign rf_g = rf_w_r ? garbage : rf_mem[1];
  assign rf_y = rf_w_r ? garbage : rf_mem[2];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 = idle, 1 = red, 2 = green, 3 = yellow.
  int m_mem[4] = '{default: 0};
  int m_sh[3]  = '{default: 0};
  int m_phase  = 0;
  int m_remain = 0;
  bit m_blink  = 0;
  bit m_done   = 0;

  function automatic int clamp1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int old_sh[3];
    if (!rst_n) begin
      m_sh = '{0, 0, 0};
      m_phase = 0; m_remain = 0; m_blink = 0; m_done = 0;
    end else begin
      old_sh = m_sh;
      if (!cfg_we) for (int i = 0; i < 3; i++) m_sh[i] = m_mem[i];
      else m_mem[cfg_addr] = int'(cfg_data);
      m_done = 0;
      if (m_phase == 0) begin
        if (run) begin
          m_phase = 1; m_remain = clamp1(old_sh[0]); m_blink = 0;
        end else if (tick) m_blink = !m_blink;
      end else if (!run) begin
        m_phase = 0; m_remain = 0; m_blink = 0;
      end else if (tick) begin
        if (m_remain == 1) begin
          m_phase = (m_phase % 3) + 1;
          m_remain = clamp1(old_sh[m_phase-1]);
          m_done = 1;
        end else m_remain--;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("m_lamp_r", int'(lamp_r), int'(m_phase == 1));
      check("m_lamp_g", int'(lamp_g), int'(m_phase == 2));
      check("m_lamp_y", int'(lamp_y), int'(m_phase == 3 || (m_phase == 0 && m_blink)));
      check("m_remain", int'(remain), m_remain);
      check("m_phase_done", int'(phase_done), int'(m_done));
      check("remain_known", int'($isunknown(remain)), 0);
      check("rf_cs", int'(rf_cs), 0);
      if (phase_done) pulses++;
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  // Caller guarantees the previous edge saw no tick.
  task automatic pulse();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic wr(input int a, input int d);
    cfg_we = 1'b1; cfg_addr = AW'(a); cfg_data = DW'(d);
    step();
    cfg_we = 1'b0;
  endtask

  task automatic expect_out(input string name, input int r, input int g, input int y,
                            input int rem, input int pd);
    check({name, "_lamp_r"}, int'(lamp_r), r);
    check({name, "_lamp_g"}, int'(lamp_g), g);
    check({name, "_lamp_y"}, int'(lamp_y), y);
    check({name, "_remain"}, int'(remain), rem);
    check({name, "_pd"}, int'(phase_done), pd);
  endtask

  int exp_rem[6] = '{2, 1, 2, 1, 1, 3};
  int exp_ph[6]  = '{1, 1, 2, 2, 3, 1};
  int exp_pd[6]  = '{0, 0, 1, 0, 1, 1};
  int sdat[4]    = '{4, 3, 2, 5};

  initial begin
    int p0;
    bit prev_tick;
    // Reset and idle blink
    step();
    expect_out("reset", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    check("blink0", int'(lamp_y), 0);
    pulse(); check("blink1", int'(lamp_y), 1); step();
    pulse(); check("blink2", int'(lamp_y), 0); step();
    pulse(); check("blink3", int'(lamp_y), 1); step();

    // Basic cycle: red 3, green 2, yellow 1
    wr(0, 3); wr(1, 2); wr(2, 1); step();
    run = 1'b1; step();
    expect_out("red_entry", 1, 0, 0, 3, 0);
    p0 = pulses;
    for (int i = 0; i < 6; i++) begin
      pulse();
      expect_out("cycle", int'(exp_ph[i] == 1), int'(exp_ph[i] == 2), int'(exp_ph[i] == 3),
                 exp_rem[i], exp_pd[i]);
      repeat (3) step();
    end
    check("pulses_per_cycle", pulses - p0, 3);

    // Zero green duration runs as one tick
    wr(1, 0); step();
    pulse(); step(); pulse(); step();
    pulse(); expect_out("zero_green", 0, 1, 0, 1, 1); step();
    pulse(); expect_out("zero_to_yel", 0, 0, 1, 1, 1); step();
    wr(1, 2); step();
    pulse(); step();
    pulse(); step(); pulse(); step();
    pulse(); expect_out("green2", 0, 1, 0, 2, 1); step();

    // Drop run together with a tick mid-green
    run = 1'b0; tick = 1'b1; step(); tick = 1'b0;
    expect_out("drop_run", 0, 0, 0, 0, 0);
    step();
    run = 1'b1; step();
    expect_out("rerun_red", 1, 0, 0, 3, 0);

    // Write green = 5 during red, with a coincident tick
    tick = 1'b1; wr(1, 5); tick = 1'b0;
    expect_out("wr_in_red", 1, 0, 0, 2, 0);
    step();
    pulse(); step();
    pulse(); expect_out("green5", 0, 1, 0, 5, 1); step();
    for (int i = 0; i < 6; i++) begin pulse(); step(); end
    pulse(); step(); pulse(); step();
    // Write issued the cycle before green entry: that green keeps 5
    wr(1, 7);
    pulse(); expect_out("green_old", 0, 1, 0, 5, 1); step();
    for (int i = 0; i < 9; i++) begin pulse(); if (i < 8) step(); end
    expect_out("green7", 0, 1, 0, 7, 1); step();

    // Back-to-back writes while running: red 5, green 3, yellow 2
    for (int i = 0; i < 4; i++) begin
      cfg_we = 1'b1; cfg_addr = AW'(i % 3); cfg_data = DW'(sdat[i]); step();
    end
    cfg_we = 1'b0;
    for (int i = 0; i < 9; i++) begin pulse(); if (i < 8) step(); end
    expect_out("stress_red", 1, 0, 0, 5, 1); step();
    for (int i = 0; i < 5; i++) begin pulse(); if (i < 4) step(); end
    expect_out("stress_green", 0, 1, 0, 3, 1); step();

    // Randomized traffic with occasional asynchronous reset
    prev_tick = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 1000 == 500) begin
        #2 rst_n = 1'b0;
        #1 expect_out("async_rst", 0, 0, 0, 0, 0);
        step();
        rst_n = 1'b1;
      end
      run      = ($urandom_range(0, 99) < 95);
      tick     = !prev_tick && ($urandom_range(0, 2) == 0);
      prev_tick = tick;
      cfg_we   = ($urandom_range(0, 7) == 0);
      cfg_addr = AW'($urandom_range(0, 3));
      cfg_data = DW'($urandom_range(0, 4));
      step();
    end
    tick = 1'b0; cfg_we = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
